// File: rtl/buzzer_tone_gen_pkg.sv
// Shared definitions for the buzzer tone generator: note pitches, FSM and octave
// encodings, and small helpers for key selection.
package buzzer_tone_gen_pkg;

  localparam int unsigned DEFAULT_CLK_HZ = 100_000_000;

  // Note pitches in Hz, C..B
  localparam int unsigned NOTE_HZ [0:6] = '{262, 294, 330, 349, 392, 440, 494};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } tone_state_e;

  typedef enum logic [1:0] {
    OCT_MID  = 2'b00,
    OCT_UP   = 2'b01,
    OCT_DOWN = 2'b10
  } octave_e;

  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input int unsigned freq_hz);
    return clk_hz / (2 * freq_hz);
  endfunction

  // Lowest set key wins; 0 means no key held.
  function automatic logic [3:0] note_select(input logic [6:0] keys);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 6; i >= 0; i--) begin
      if (keys[i]) idx = 4'(i + 1);
    end
    return idx;
  endfunction

  function automatic octave_e octave_decode(input logic up, input logic down);
    octave_e oct;
    case ({down, up})
      2'b01:   oct = OCT_UP;
      2'b10:   oct = OCT_DOWN;
      default: oct = OCT_MID;
    endcase
    return oct;
  endfunction

endpackage

// File: rtl/buzzer_tone_gen_debouncer.sv
// Key conditioner: 2-FF synchroniser, then a candidate/counter filter that only
// accepts a vector after it has stayed unchanged for CYCLES consecutive samples.
module pin_debouncer #(
  parameter int unsigned WIDTH  = 9,
  parameter int unsigned CYCLES = 2_000_000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] pins_i,
  output logic [WIDTH-1:0] stable_o
);

  localparam int unsigned CW = $clog2(CYCLES + 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Counter saturates at CYCLES so a long-held vector is accepted only once.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CW'(CYCLES)) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(CYCLES - 1)) stable_d = cand_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= pins_i;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/buzzer_tone_gen.sv
// Piezo tone generator: debounced note/octave keys select a pitch, and a
// half-period counter toggles the speaker, retuning only on half-period edges.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | silent, speaker low, counter held at zero
//   ST_PLAY | square wave running; toggle and retune when cnt hits half-1
module buzzer_tone_gen
  import buzzer_tone_gen_pkg::*;
#(
  parameter int unsigned CLK_HZ          = DEFAULT_CLK_HZ,
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic [8:0] pin_note_i,
  output logic       speaker_o,
  output logic [3:0] note_idx_o,
  output logic [1:0] octave_o,
  output logic [7:0] led_note_o
);

  localparam logic [CNT_W-1:0] HALF_TAB [0:7] = '{
    '0,
    CNT_W'(half_period(CLK_HZ, NOTE_HZ[0])),
    CNT_W'(half_period(CLK_HZ, NOTE_HZ[1])),
    CNT_W'(half_period(CLK_HZ, NOTE_HZ[2])),
    CNT_W'(half_period(CLK_HZ, NOTE_HZ[3])),
    CNT_W'(half_period(CLK_HZ, NOTE_HZ[4])),
    CNT_W'(half_period(CLK_HZ, NOTE_HZ[5])),
    CNT_W'(half_period(CLK_HZ, NOTE_HZ[6]))
  };

  logic [8:0]       keys;
  logic [3:0]       note_idx;
  octave_e          octave;
  logic [CNT_W-1:0] base_half;
  logic [CNT_W-1:0] target;

  tone_state_e      state_q, state_d;
  logic             speaker_q, speaker_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;

  pin_debouncer #(
    .WIDTH  (9),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .pins_i   (pin_note_i),
    .stable_o (keys)
  );

  assign note_idx  = note_select(keys[6:0]);
  assign octave    = octave_decode(keys[7], keys[8]);
  assign base_half = HALF_TAB[note_idx[2:0]];

  always_comb begin
    case (octave)
      OCT_UP:   target = base_half >> 1;
      OCT_DOWN: target = base_half << 1;
      default:  target = base_half;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    speaker_d = speaker_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    case (state_q)
      ST_IDLE: begin
        speaker_d = 1'b0;
        cnt_d     = '0;
        if (enable_i && note_idx != 4'd0) begin
          state_d   = ST_PLAY;
          speaker_d = 1'b1;
          half_d    = target;
        end
      end
      ST_PLAY: begin
        if (!enable_i || note_idx == 4'd0) begin
          state_d   = ST_IDLE;
          speaker_d = 1'b0;
          cnt_d     = '0;
        end else if (cnt_q == half_q - CNT_W'(1)) begin
          speaker_d = ~speaker_q;
          cnt_d     = '0;
          half_d    = target;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      speaker_q <= 1'b0;
      cnt_q     <= '0;
      half_q    <= '0;
    end else begin
      state_q   <= state_d;
      speaker_q <= speaker_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
    end
  end

  // Isolate the lowest set key for the one-hot LED field.
  assign led_note_o = {state_q == ST_PLAY, keys[6:0] & (~keys[6:0] + 7'd1)};
  assign speaker_o  = speaker_q;
  assign note_idx_o = note_idx;
  assign octave_o   = octave;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Bench for buzzer_tone_gen: pitch-level model checked every cycle, plus
// directed literal checks on latency, half-period lengths and mid-tone events.
module tb_buzzer_tone_gen;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       enable   = 1'b0;
  logic [8:0] pin_note = 9'h000;
  logic       speaker_o;
  logic [3:0] note_idx_o;
  logic [1:0] octave_o;
  logic [7:0] led_note_o;

  int n_cmp = 0;
  int n_bad = 0;

  buzzer_tone_gen #(
    .CLK_HZ          (1_000_000),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (20)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .enable_i   (enable),
    .pin_note_i (pin_note),
    .speaker_o  (speaker_o),
    .note_idx_o (note_idx_o),
    .octave_o   (octave_o),
    .led_note_o (led_note_o)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  localparam int FREQ [0:6] = '{262, 294, 330, 349, 392, 440, 494};

  function automatic int note_of(input logic [6:0] k);
    for (int i = 0; i < 7; i++) if (k[i]) return i + 1;
    return 0;
  endfunction

  function automatic int oct_of(input logic up, input logic down);
    if (up && !down) return 1;
    if (down && !up) return 2;
    return 0;
  endfunction

  function automatic int half_of(input int note, input int oct);
    int base;
    if (note == 0) return 0;
    base = 1_000_000 / (2 * FREQ[note - 1]);
    if (oct == 1) return base / 2;
    if (oct == 2) return base * 2;
    return base;
  endfunction

  logic [8:0] m_stable = '0;
  logic [8:0] h [0:6] = '{default: 9'h000};  // h[0] = newest sampled pin vector
  logic       m_play = 1'b0;
  logic       m_spk  = 1'b0;
  int         m_rem  = 0;

  initial begin
    logic [14:0] expv, actv;
    int nt, oc, tg;
    logic [7:0] led;
    forever begin
      @(negedge clk);
      nt  = note_of(m_stable[6:0]);
      oc  = oct_of(m_stable[7], m_stable[8]);
      led = {m_play, (nt == 0) ? 7'h00 : 7'(1 << (nt - 1))};
      expv = {m_spk, 4'(nt), 2'(oc), led};
      actv = {speaker_o, note_idx_o, octave_o, led_note_o};
      n_cmp++;
      if (actv !== expv) begin
        n_bad++;
        $display("FAIL model_cycle t=%0t actual spk/note/oct/led=%h required=%h", $time, actv, expv);
      end
      // advance model across the coming posedge
      tg = half_of(nt, oc);
      if (rst) begin
        m_play = 1'b0; m_spk = 1'b0;
      end else if (!m_play) begin
        if (enable && nt != 0) begin m_play = 1'b1; m_spk = 1'b1; m_rem = tg; end
      end else if (!enable || nt == 0) begin
        m_play = 1'b0; m_spk = 1'b0;
      end else begin
        m_rem--;
        if (m_rem == 0) begin m_spk = ~m_spk; m_rem = tg; end
      end
      for (int i = 6; i > 0; i--) h[i] = h[i - 1];
      h[0] = rst ? 9'h000 : pin_note;
      if (rst) begin
        h[1] = 9'h000;
        m_stable = 9'h000;
      end else if (h[2] == h[3] && h[2] == h[4] && h[2] == h[5] && h[2] == h[6]) begin
        // accepted once the synchronised value held for DEBOUNCE_CYCLES+1 samples
        m_stable = h[2];
      end
    end
  end

  // ---------------- half-period monitor ----------------
  int  hq[$];
  time last_t = 0;
  logic prev_spk = 1'b0;
  bit  valid = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (led_note_o[7] !== 1'b1) valid = 1'b0;
      else if (speaker_o !== prev_spk) begin
        if (valid) hq.push_back(int'(($time - last_t) / 10));
        valid  = 1'b1;
        last_t = $time;
      end
      prev_spk = speaker_o;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_halves(input int k, input string name);
    int b = 0;
    while (hq.size() < k && b < 20000) begin
      @(posedge clk);
      b++;
    end
    #2;
    if (hq.size() < k) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: actual=%0d halves required=%0d", name, hq.size(), k);
    end
  endtask

  function automatic int hget(input int i);
    return (hq.size() > i) ? hq[i] : -1;
  endfunction

  // ---------------- directed stimulus ----------------
  logic [8:0] oct_pins [0:2] = '{9'h0A0, 9'h120, 9'h1A0};
  int         oct_half [0:2] = '{568, 2272, 1136};
  int         oct_code [0:2] = '{1, 2, 0};

  initial begin
    cyc(3);
    check("reset_outputs", {23'd0, speaker_o, note_idx_o, octave_o, led_note_o}, 32'd0);
    rst = 1'b0;
    cyc(8);

    // note A: latency and steady tone
    enable = 1'b1;
    pin_note = 9'h020;
    cyc(6);
    check("latency_before", note_idx_o, 0);
    cyc(1);
    check("latency_note", note_idx_o, 6);
    check("led_not_yet_playing", led_note_o, 8'h20);
    cyc(1);
    check("led_playing", led_note_o, 8'hA0);
    check("speaker_start", speaker_o, 1);
    hq.delete();
    wait_halves(2, "tone_a");
    check("a_high", hget(0), 1136);
    check("a_low", hget(1), 1136);

    // octave keys
    for (int i = 0; i < 3; i++) begin
      pin_note = oct_pins[i];
      hq.delete();
      wait_halves(3, "octave");
      check("octave_half", hget(2), oct_half[i]);
      check("octave_code", octave_o, oct_code[i]);
    end

    // chord -> lowest key
    pin_note = 9'h005;
    hq.delete();
    wait_halves(3, "chord");
    check("chord_half", hget(2), 1908);
    check("chord_note", note_idx_o, 1);
    check("chord_led", led_note_o, 8'h81);

    // A -> C switch 300 cycles into a half-period
    pin_note = 9'h020;
    cyc(8);
    hq.delete();
    wait_halves(1, "sync");
    cyc(299);
    pin_note = 9'h001;
    hq.delete();
    wait_halves(2, "switch");
    check("switch_finish_old", hget(0), 1136);
    check("switch_new", hget(1), 1908);

    // enable drop mid-tone
    cyc(200);
    enable = 1'b0;
    cyc(1);
    check("disable_speaker", speaker_o, 0);
    check("disable_led", led_note_o, 8'h01);
    cyc(5);
    check("disabled_note_kept", note_idx_o, 1);
    enable = 1'b1;
    cyc(2);
    check("reenable_play", led_note_o[7], 1);

    // reset mid-tone
    cyc(150);
    rst = 1'b1;
    cyc(1);
    check("midreset_outputs", {23'd0, speaker_o, note_idx_o, octave_o, led_note_o}, 32'd0);
    rst = 1'b0;
    cyc(6);
    check("midreset_debounce_restart", note_idx_o, 0);
    cyc(1);
    check("midreset_recover", note_idx_o, 1);

    // bounce and short glitch are rejected
    pin_note = 9'h000;
    cyc(12);
    for (int i = 0; i < 10; i++) begin
      pin_note[0] = ~pin_note[0];
      cyc(2);
    end
    pin_note = 9'h000;
    cyc(10);
    check("bounce_note", note_idx_o, 0);
    check("bounce_speaker", speaker_o, 0);
    pin_note = 9'h004;
    cyc(3);
    pin_note = 9'h000;
    cyc(12);
    check("glitch_note", note_idx_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
